pmem_responder: RTL and testbench

PMEM_RESPONDER -- requirements
Module: pmem_responder

---
 rtl/npc_pkg.sv | 19 +
 rtl/pmem_sram.sv | 27 ++
 rtl/pmem_responder.sv | 133 +++++++++++++
 tb/tb_pmem_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared constants for the pmem responder: FSM state encodings, legal access
// masks and the default memory base address.
package npc_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [7:0] MASK_BYTE = 8'h01;
  localparam logic [7:0] MASK_HALF = 8'h03;
  localparam logic [7:0] MASK_WORD = 8'h0F;

  function automatic logic mask_legal(input logic [7:0] mask);
    return (mask == MASK_BYTE) || (mask == MASK_HALF) || (mask == MASK_WORD);
  endfunction

endpackage

// File: rtl/pmem_sram.sv
// Word-organised storage with per-byte write enables and a registered read port.
// Contents are deliberately never reset.
module pmem_sram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              wen,
  input  logic [3:0]        be,
  input  logic              ren,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wen) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (ren) rdata <= mem[addr];
  end

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency memory responder: accepts one request at a time, performs the
// access after LATENCY cycles and holds the response until the initiator takes it.
module pmem_responder
  import npc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          ADDR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        lat_wen;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [7:0]  lat_wmask;

  assign req_ready = (state == ST_IDLE);

  // With LATENCY=1 the access commits on the accepting edge itself, so the
  // live request is used there; in every other case the latched copy is used.
  logic        cur_wen;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [7:0]  cur_wmask;
  assign cur_wen   = req_ready ? req_wen   : lat_wen;
  assign cur_addr  = req_ready ? req_addr  : lat_addr;
  assign cur_wdata = req_ready ? req_wdata : lat_wdata;
  assign cur_wmask = req_ready ? req_wmask : lat_wmask;

  logic enter_resp;
  assign enter_resp = req_ready ? (req_valid && (LAT_M1 == 4'd0))
                                : ((state == ST_WAIT) && (cnt == 4'd1));

  logic [32:0] offs;
  logic        in_range;
  logic [1:0]  lane;
  logic [7:0]  shifted_mask;
  logic        err;
  assign offs         = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
  assign in_range     = !offs[32] && (offs < SPAN);
  assign lane         = cur_addr[1:0];
  assign shifted_mask = {4'b0000, cur_wmask[3:0]} << lane;
  assign err          = !in_range || !mask_legal(cur_wmask) || (shifted_mask[7:4] != 4'b0000);

  logic [31:0] sram_rdata;

  pmem_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_sram (
    .clk  (clk),
    .wen  (enter_resp && cur_wen && !err),
    .be   (shifted_mask[3:0]),
    .ren  (enter_resp && !cur_wen && !err),
    .addr (offs[ADDR_W+1:2]),
    .wdata(cur_wdata << {lane, 3'b000}),
    .rdata(sram_rdata)
  );

  // Load data is aligned and width-trimmed from the registered SRAM word.
  logic [31:0] aligned_q;
  logic [31:0] width_mask;
  assign aligned_q = sram_rdata >> {lat_addr[1:0], 3'b000};

  always_comb begin
    width_mask = 32'hFFFF_FFFF;
    if (lat_wmask == MASK_BYTE)      width_mask = 32'h0000_00FF;
    else if (lat_wmask == MASK_HALF) width_mask = 32'h0000_FFFF;
  end

  assign resp_rdata = (resp_valid && !resp_err && !lat_wen) ? (aligned_q & width_mask) : 32'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      lat_wen    <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_wmask  <= 8'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_wen   <= req_wen;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wmask <= req_wmask;
            cnt       <= LAT_M1;
            state     <= (LAT_M1 == 4'd0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (enter_resp) begin
        resp_valid <= 1'b1;
        resp_err   <= err;
      end
    end
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: one LATENCY=2 instance for the main
// sequence and one LATENCY=1 instance for back-to-back throughput.
module tb_pmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        l1_req_valid, l1_req_ready, l1_req_wen;
  logic [31:0] l1_req_addr, l1_req_wdata;
  logic [7:0]  l1_req_wmask;
  logic        l1_resp_valid, l1_resp_ready, l1_resp_err;
  logic [31:0] l1_resp_rdata;

  int compared   = 0;
  int mismatched = 0;

  pmem_responder #(.LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  pmem_responder #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_wen(l1_req_wen),
    .req_addr(l1_req_addr), .req_wdata(l1_req_wdata), .req_wmask(l1_req_wmask),
    .resp_valid(l1_resp_valid), .resp_ready(l1_resp_ready),
    .resp_rdata(l1_resp_rdata), .resp_err(l1_resp_err)
  );

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one request, wait for acceptance and the response; inputs are
  // scrambled right after acceptance to show they are ignored afterwards.
  task automatic apply_stimulus(input string tag, input logic wen, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [7:0] wmask,
                                output logic [31:0] rdata, output logic err);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    resp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_bit({tag, "_ready"}, req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_wen = ~wen; req_addr = 32'hFFFF_FFFF; req_wdata = ~wdata; req_wmask = 8'hFF;
    n = 1;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_bit({tag, "_valid"}, resp_valid, 1'b1);
    check_word({tag, "_latency"}, 32'(n), 32'd2);
    rdata = resp_rdata;
    err   = resp_err;
  endtask

  task automatic finish_resp(input string tag);
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check_bit({tag, "_released"}, resp_valid, 1'b0);
  endtask

  task automatic check_output(input string tag, input logic wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [7:0] wmask,
                              input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rdata;
    logic        err;
    apply_stimulus(tag, wen, addr, wdata, wmask, rdata, err);
    check_word({tag, "_rdata"}, rdata, exp_rdata);
    check_bit({tag, "_err"}, err, exp_err);
    finish_resp(tag);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          op;
    int          k;

    reset = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_wmask = 8'h0F;
    resp_ready = 1'b0;
    l1_req_valid = 1'b0; l1_req_wen = 1'b0; l1_req_addr = 32'd0; l1_req_wdata = 32'd0;
    l1_req_wmask = 8'h0F; l1_resp_ready = 1'b0;

    #1 reset = 1'b0;
    #2;
    $display("[TB] reset state");
    check_bit("rst_req_ready", req_ready, 1'b1);
    check_bit("rst_resp_valid", resp_valid, 1'b0);
    check_bit("rst_resp_err", resp_err, 1'b0);
    check_word("rst_resp_rdata", resp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    $display("[TB] word store then load");
    check_output("st_word", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 32'd0, 1'b0);
    check_output("ld_word", 1'b0, 32'h8000_0010, 32'h0, 8'h0F, 32'hDEAD_BEEF, 1'b0);

    $display("[TB] byte/half lanes");
    check_output("st_init", 1'b1, 32'h8000_0010, 32'h1122_3344, 8'h0F, 32'd0, 1'b0);
    check_output("st_byte3", 1'b1, 32'h8000_0013, 32'h5A5A_5AAB, 8'h01, 32'd0, 1'b0);
    check_output("ld_merged", 1'b0, 32'h8000_0010, 32'h0, 8'h0F, 32'hAB22_3344, 1'b0);
    check_output("ld_byte3", 1'b0, 32'h8000_0013, 32'h0, 8'h01, 32'h0000_00AB, 1'b0);
    check_output("ld_half2", 1'b0, 32'h8000_0012, 32'h0, 8'h03, 32'h0000_AB22, 1'b0);
    check_output("ld_byte1", 1'b0, 32'h8000_0011, 32'h0, 8'h01, 32'h0000_0033, 1'b0);

    $display("[TB] error cases");
    check_output("st_base", 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 8'h0F, 32'd0, 1'b0);
    check_output("ld_below", 1'b0, 32'h7FFF_FFFC, 32'h0, 8'h0F, 32'd0, 1'b1);
    check_output("st_cross", 1'b1, 32'h8000_0003, 32'h0000_BEEF, 8'h03, 32'd0, 1'b1);
    check_output("ld_base", 1'b0, 32'h8000_0000, 32'h0, 8'h0F, 32'hCAFE_F00D, 1'b0);
    check_output("ld_mask07", 1'b0, 32'h8000_0000, 32'h0, 8'h07, 32'd0, 1'b1);
    check_output("st_above", 1'b1, 32'h8000_4000, 32'h1234_5678, 8'h0F, 32'd0, 1'b1);
    check_output("st_top", 1'b1, 32'h8000_3FFC, 32'h0BAD_F00D, 8'h0F, 32'd0, 1'b0);
    check_output("ld_top", 1'b0, 32'h8000_3FFC, 32'h0, 8'h0F, 32'h0BAD_F00D, 1'b0);

    $display("[TB] backpressure");
    apply_stimulus("bp", 1'b0, 32'h8000_0010, 32'h0, 8'h0F, rd, er);
    check_word("bp_rdata", rd, 32'hAB22_3344);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_3FFC; req_wmask = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_bit($sformatf("bp_hold_valid_%0d", i), resp_valid, 1'b1);
      check_word($sformatf("bp_hold_rdata_%0d", i), resp_rdata, 32'hAB22_3344);
      check_bit($sformatf("bp_hold_ready_%0d", i), req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check_bit("bp_hs_valid", resp_valid, 1'b0);
    check_bit("bp_idle_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_bit("bp_next_accepted", req_ready, 1'b0);
    @(posedge clk);
    #1;
    check_bit("bp_next_valid", resp_valid, 1'b1);
    check_word("bp_next_rdata", resp_rdata, 32'h0BAD_F00D);
    finish_resp("bp_next");

    $display("[TB] reset during WAIT");
    check_output("st_prior", 1'b1, 32'h8000_0020, 32'h1111_1111, 8'h0F, 32'd0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'h1234_5678; req_wmask = 8'h0F;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_bit("mid_in_wait", req_ready, 1'b0);
    reset = 1'b0;
    #1;
    check_bit("mid_req_ready", req_ready, 1'b1);
    check_bit("mid_resp_valid", resp_valid, 1'b0);
    check_bit("mid_resp_err", resp_err, 1'b0);
    check_word("mid_resp_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_output("ld_after_rst", 1'b0, 32'h8000_0020, 32'h0, 8'h0F, 32'h1111_1111, 1'b0);

    $display("[TB] LATENCY=1 back-to-back");
    l1_resp_ready = 1'b1;
    l1_req_valid  = 1'b1;
    l1_req_addr   = 32'h8000_0040;
    l1_req_wmask  = 8'h0F;
    op = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_bit($sformatf("l1_ready_%0d", i), l1_req_ready, logic'(i % 2 == 0));
      check_bit($sformatf("l1_valid_%0d", i), l1_resp_valid, logic'(i % 2 == 1));
      if (l1_resp_valid) begin
        k = op - 1;
        check_word($sformatf("l1_rdata_op%0d", k), l1_resp_rdata,
                   (k % 2 == 0) ? 32'd0 : 32'h1000_0000 + 32'(k - 1));
        check_bit($sformatf("l1_err_op%0d", k), l1_resp_err, 1'b0);
      end
      if (l1_req_ready) begin
        l1_req_wen   = (op % 2 == 0);
        l1_req_wdata = 32'h1000_0000 + 32'(op);
        op++;
      end
    end
    l1_req_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
